// File: rtl/c2h_pkt_reader.sv
// Streams one IPbus reply packet from the tx buffer onto the XDMA C2H AXI4-Stream.
// Header word gives the 32-bit payload length; reads are throttled by a 2-entry output FIFO.
module c2h_pkt_reader #(
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int ADDR_W             = 10
) (
  input  logic                            user_clk,
  input  logic                            sys_rst_n,
  input  logic                            ipb_pkt_done_pcieclk,
  output logic                            ram_rd_en,
  output logic [ADDR_W:0]                 ram_rd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   ram_rd_data,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axis_c2h_tdata,
  output logic [7:0]                      m_axis_c2h_tkeep,
  output logic                            m_axis_c2h_tlast,
  output logic                            m_axis_c2h_tvalid,
  input  logic                            m_axis_c2h_tready,
  output logic                            c2h_busy,
  output logic                            c2h_done,
  output logic [15:0]                     pkt_count,
  output logic                            len_err
);

  // state  | meaning
  // IDLE   | waiting for a packet-complete edge or a pending start
  // HDR    | read of header word 0 issued
  // HWAIT  | header on read port; length decoded, first payload read may issue
  // STREAM | payload reads and beats in progress until the tlast handshake
  // DONE   | c2h_done pulse, pkt_count already updated
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_HWAIT  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Largest payload that fits the buffer: header plus (depth-1) words of two halves each.
  localparam logic [ADDR_W:0] MAX_N = (ADDR_W+1)'(2 * ((1 << ADDR_W) - 1));

  logic [2:0]                    r_state;
  logic [2:0]                    w_state_nxt;
  logic                          r_pkt_done_d;
  logic                          r_pending;
  logic [ADDR_W:0]               r_rd_next;
  logic [ADDR_W:0]               r_beats;
  logic                          r_odd;
  logic                          r_rd_en_d;
  logic                          r_rd_last_d;
  logic [7:0]                    r_rd_keep_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_fifo_data [2];
  logic [7:0]                    r_fifo_keep [2];
  logic                          r_fifo_last [2];
  logic                          r_wr_ptr;
  logic                          r_rd_ptr;
  logic [1:0]                    r_count;
  logic [15:0]                   r_pkt_count;
  logic                          r_len_err;

  logic                          w_edge;
  logic [15:0]                   w_hdr_n;
  logic                          w_clamp;
  logic [ADDR_W:0]               w_n_eff;
  logic [ADDR_W:0]               w_hdr_beats;
  logic [ADDR_W:0]               w_beats_cur;
  logic                          w_odd_cur;
  logic                          w_pop;
  logic                          w_push;
  logic                          w_push_last;
  logic [7:0]                    w_push_keep;
  logic [1:0]                    w_occ_sum;
  logic                          w_rd_issue;
  logic                          w_rd_last;
  logic [7:0]                    w_rd_keep;
  logic                          w_head_last;
  logic                          w_in_hwait;

  assign w_edge  = ipb_pkt_done_pcieclk & ~r_pkt_done_d;

  assign w_hdr_n     = ram_rd_data[15:0];
  assign w_clamp     = w_hdr_n > 16'(MAX_N);
  assign w_n_eff     = w_clamp ? MAX_N : w_hdr_n[ADDR_W:0];
  assign w_hdr_beats = {1'b0, w_n_eff[ADDR_W:1]} + {{ADDR_W{1'b0}}, w_n_eff[0]} + {{ADDR_W{1'b0}}, 1'b1};

  // In HWAIT the length is only available combinationally from the read port.
  assign w_in_hwait  = (r_state == S_HWAIT);
  assign w_beats_cur = w_in_hwait ? w_hdr_beats : r_beats;
  assign w_odd_cur   = w_in_hwait ? w_n_eff[0]  : r_odd;

  assign w_pop       = (r_count != 2'd0) && m_axis_c2h_tready;
  assign w_push      = r_rd_en_d;
  assign w_occ_sum   = r_count + {1'b0, r_rd_en_d} - {1'b0, w_pop};
  assign w_head_last = r_fifo_last[r_rd_ptr];

  assign w_rd_issue = (r_state == S_HDR) ||
                      (((r_state == S_HWAIT) || (r_state == S_STREAM)) &&
                       (r_rd_next < w_beats_cur) && (w_occ_sum < 2'd2));
  assign w_rd_last  = (r_rd_next == w_beats_cur - {{ADDR_W{1'b0}}, 1'b1});
  assign w_rd_keep  = (w_rd_last && w_odd_cur) ? 8'h0F : 8'hFF;

  assign w_push_last = w_in_hwait ? (w_hdr_beats == {{ADDR_W{1'b0}}, 1'b1}) : r_rd_last_d;
  assign w_push_keep = w_in_hwait ? 8'hFF : r_rd_keep_d;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_edge || r_pending) w_state_nxt = S_HDR;
      S_HDR:    w_state_nxt = S_HWAIT;
      S_HWAIT:  w_state_nxt = S_STREAM;
      S_STREAM: if (w_pop && w_head_last) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_pkt_done_d <= 1'b0;
      r_pending    <= 1'b0;
      r_rd_next    <= '0;
      r_beats      <= '0;
      r_odd        <= 1'b0;
      r_rd_en_d    <= 1'b0;
      r_rd_last_d  <= 1'b0;
      r_rd_keep_d  <= 8'h00;
      r_pkt_count  <= 16'h0000;
      r_len_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pkt_done_d <= ipb_pkt_done_pcieclk;
      r_rd_en_d    <= w_rd_issue;
      r_rd_last_d  <= w_rd_last;
      r_rd_keep_d  <= w_rd_keep;
      // Leaving IDLE consumes any pending start; one extra edge is remembered while busy.
      if (r_state == S_IDLE)
        r_pending <= 1'b0;
      else if (w_edge)
        r_pending <= 1'b1;
      if (r_state == S_IDLE)
        r_rd_next <= '0;
      else if (w_rd_issue)
        r_rd_next <= r_rd_next + {{ADDR_W{1'b0}}, 1'b1};
      if (w_in_hwait) begin
        r_beats <= w_hdr_beats;
        r_odd   <= w_n_eff[0];
        if (w_clamp)
          r_len_err <= 1'b1;
      end
      if ((r_state == S_STREAM) && (w_state_nxt == S_DONE))
        r_pkt_count <= r_pkt_count + 16'h0001;
    end
  end

  always_ff @(posedge user_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_keep[0] <= 8'h00;
      r_fifo_keep[1] <= 8'h00;
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= ram_rd_data;
        r_fifo_keep[r_wr_ptr] <= w_push_keep;
        r_fifo_last[r_wr_ptr] <= w_push_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign ram_rd_en         = w_rd_issue;
  assign ram_rd_addr       = {1'b0, r_rd_next[ADDR_W-1:0]};
  assign m_axis_c2h_tvalid = (r_count != 2'd0);
  assign m_axis_c2h_tdata  = r_fifo_data[r_rd_ptr];
  assign m_axis_c2h_tkeep  = r_fifo_keep[r_rd_ptr];
  assign m_axis_c2h_tlast  = r_fifo_last[r_rd_ptr];
  assign c2h_busy          = (r_state == S_HDR) || (r_state == S_HWAIT) || (r_state == S_STREAM);
  assign c2h_done          = (r_state == S_DONE);
  assign pkt_count         = r_pkt_count;
  assign len_err           = r_len_err;

endmodule

// File: tb/tb_c2h_pkt_reader.sv
// Bench for c2h_pkt_reader: buffer memory model, expected-beat queue built from header rules,
// per-cycle stream/read checker, and directed timing checks with literal expectations.
module tb_c2h_pkt_reader;

  logic        clk;
  logic        sys_rst_n;
  logic        ipb;
  logic        ram_rd_en;
  logic [10:0] ram_rd_addr;
  logic [63:0] ram_rd_data;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        c2h_busy;
  logic        c2h_done;
  logic [15:0] pkt_count;
  logic        len_err;

  c2h_pkt_reader #(.C_M_AXI_DATA_WIDTH(64), .ADDR_W(10)) dut (
    .user_clk             (clk),
    .sys_rst_n            (sys_rst_n),
    .ipb_pkt_done_pcieclk (ipb),
    .ram_rd_en            (ram_rd_en),
    .ram_rd_addr          (ram_rd_addr),
    .ram_rd_data          (ram_rd_data),
    .m_axis_c2h_tdata     (tdata),
    .m_axis_c2h_tkeep     (tkeep),
    .m_axis_c2h_tlast     (tlast),
    .m_axis_c2h_tvalid    (tvalid),
    .m_axis_c2h_tready    (tready),
    .c2h_busy             (c2h_busy),
    .c2h_done             (c2h_done),
    .pkt_count            (pkt_count),
    .len_err              (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic [63:0] mem [1024];
  beat_t       exp_q [$];
  int          pkt_b_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          issued, accepted, rd_exp, pkt_beats, beats_seen, max_addr;
  logic [15:0] model_pkt;
  logic [7:0]  last_keep;
  logic        last_last;
  logic        prev_stall;
  logic [63:0] hold_d;
  logic [7:0]  hold_k;
  logic        hold_l;
  logic        rnd_ready;
  logic        hs;
  int          bmax;
  beat_t       e;

  // one-cycle-latency buffer read port
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr[9:0]];
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    pkt_b_q.delete();
    model_pkt  = 16'h0000;
    rd_exp     = 0;
    issued     = 0;
    accepted   = 0;
    pkt_beats  = 0;
    prev_stall = 1'b0;
  endtask

  // Expected beats follow from the header alone: B = 1 + ceil(N/2), N clamped to 2046.
  task automatic expect_packet();
    int    n;
    int    b;
    beat_t x;
    n = int'(mem[0][15:0]);
    if (n > 2046) n = 2046;
    b = 1 + (n + 1) / 2;
    pkt_b_q.push_back(b);
    for (int k = 0; k < b; k++) begin
      x.d = mem[k];
      x.l = (k == b - 1);
      x.k = (x.l && (n % 2 == 1)) ? 8'h0F : 8'hFF;
      exp_q.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    if (!sys_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      hs = tvalid && tready;
      if (prev_stall) begin
        n_vec++;
        if (!tvalid || tdata !== hold_d || tkeep !== hold_k || tlast !== hold_l) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b held d=%h k=%h l=%b",
                   tvalid, tdata, tkeep, tlast, hold_d, hold_k, hold_l);
        end
      end
      if (ram_rd_en) begin
        n_vec++;
        bmax = (pkt_b_q.size() > 0) ? pkt_b_q[0] : 0;
        if (ram_rd_addr !== 11'(rd_exp) || rd_exp >= bmax ||
            (issued - accepted + 1 - (hs ? 1 : 0)) > 2) begin
          n_err++;
          $display("FAIL rd_issue: got addr=%0d outstanding=%0d expected addr=%0d beats=%0d max2",
                   ram_rd_addr, issued - accepted + 1 - (hs ? 1 : 0), rd_exp, bmax);
        end
        if (int'(ram_rd_addr) > max_addr) max_addr = int'(ram_rd_addr);
        rd_exp++;
      end
      if (hs) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat: got unexpected d=%h k=%h l=%b expected none", tdata, tkeep, tlast);
        end else begin
          e = exp_q.pop_front();
          if (tdata !== e.d || tkeep !== e.k || tlast !== e.l) begin
            n_err++;
            $display("FAIL beat: got d=%h k=%h l=%b expected d=%h k=%h l=%b",
                     tdata, tkeep, tlast, e.d, e.k, e.l);
          end
        end
        beats_seen++;
        pkt_beats++;
        last_keep = tkeep;
        last_last = tlast;
      end
      if (c2h_done) begin
        n_vec++;
        bmax = (pkt_b_q.size() > 0) ? pkt_b_q[0] : -1;
        if (pkt_count !== model_pkt + 16'h0001 || pkt_beats != bmax || c2h_busy !== 1'b0) begin
          n_err++;
          $display("FAIL done: got count=%0d beats=%0d busy=%b expected count=%0d beats=%0d busy=0",
                   pkt_count, pkt_beats, c2h_busy, model_pkt + 16'h0001, bmax);
        end
        if (pkt_b_q.size() > 0) void'(pkt_b_q.pop_front());
        model_pkt = model_pkt + 16'h0001;
        rd_exp    = 0;
        issued    = 0;
        accepted  = 0;
        pkt_beats = 0;
      end
      issued     = issued + (ram_rd_en ? 1 : 0);
      accepted   = accepted + (hs ? 1 : 0);
      prev_stall = tvalid && !tready;
      hold_d     = tdata;
      hold_k     = tkeep;
      hold_l     = tlast;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hdr(input logic [15:0] n);
    mem[0] = {32'h4844_5200, 16'h00A5, n};
  endtask

  task automatic wait_done(input int limit);
    bit got;
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (c2h_done) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no c2h_done expected within %0d cycles", limit);
    end
  endtask

  task automatic run_pkt(input logic [15:0] n, input int limit);
    step();
    set_hdr(n);
    beats_seen = 0;
    max_addr   = -1;
    expect_packet();
    ipb = 1'b1;
    step();
    ipb = 1'b0;
    wait_done(limit);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    sys_rst_n = 1'b0;
    ipb       = 1'b0;
    tready    = 1'b1;
    rnd_ready = 1'b0;
    model_clear();
    for (int k = 0; k < 1024; k++)
      mem[k] = {16'hC0DE, 6'h00, 10'(k), 16'h5A00 ^ 16'(k * 7), 16'(k)};

    // reset values
    repeat (2) @(negedge clk);
    check("rst_stream", {tvalid, tlast, tkeep}, 64'h0);
    check("rst_tdata", tdata, 64'h0);
    check("rst_ctl", {ram_rd_en, ram_rd_addr, c2h_busy, c2h_done, len_err}, 64'h0);
    check("rst_pkt_count", pkt_count, 64'h0);
    do_reset();

    // N=4, tready=1: cycle-exact timing against literals
    set_hdr(16'd4);
    expect_packet();
    ipb = 1'b1;
    @(posedge clk);
    #1;
    ipb = 1'b0;
    @(negedge clk);
    check("t1_hdr_read", {c2h_busy, ram_rd_en, ram_rd_addr, tvalid}, {1'b1, 1'b1, 11'd0, 1'b0});
    @(negedge clk);
    check("t2_no_valid", tvalid, 64'h0);
    @(negedge clk);
    check("t3_beat0", {tvalid, tlast, tkeep, tdata}, {1'b1, 1'b0, 8'hFF, 64'h4844_5200_00A5_0004});
    @(negedge clk);
    check("t4_beat1", {tvalid, tlast, tdata}, {1'b1, 1'b0, 64'hC0DE_0001_5A07_0001});
    @(negedge clk);
    check("t5_beat2", {tvalid, tlast, tkeep, tdata}, {1'b1, 1'b1, 8'hFF, 64'hC0DE_0002_5A0E_0002});
    @(negedge clk);
    check("t6_done", {c2h_done, c2h_busy, tvalid, pkt_count}, {1'b1, 1'b0, 1'b0, 16'd1});

    // odd length and empty payload
    run_pkt(16'd5, 100);
    check("n5_beats", beats_seen, 64'd4);
    check("n5_last", {last_last, last_keep}, {1'b1, 8'h0F});
    run_pkt(16'd0, 100);
    check("n0_beats", beats_seen, 64'd1);
    check("n0_last", {last_last, last_keep}, {1'b1, 8'hFF});

    // N=6 under random backpressure
    rnd_ready = 1'b1;
    run_pkt(16'd6, 400);
    rnd_ready = 1'b0;
    tready    = 1'b1;
    check("n6_beats", beats_seen, 64'd4);
    check("n6_len_err", len_err, 64'h0);
    rnd_ready = 1'b1;
    run_pkt(16'd11, 400);
    rnd_ready = 1'b0;
    tready    = 1'b1;
    check("n11_last", {beats_seen, last_keep}, {32'd7, 8'h0F});

    // length clamp
    run_pkt(16'd3000, 3000);
    check("clamp_beats", beats_seen, 64'd1024);
    check("clamp_max_addr", max_addr, 64'd1023);
    check("clamp_len_err", len_err, 64'h1);
    run_pkt(16'd2, 100);
    check("len_err_sticky", {len_err, beats_seen}, {1'b1, 32'd2});

    // mid-stream edge becomes pending, third edge dropped
    do_reset();
    set_hdr(16'd6);
    expect_packet();
    expect_packet();
    ipb = 1'b1;
    step();
    ipb = 1'b0;
    step();
    step();
    ipb = 1'b1;
    step();
    ipb = 1'b0;
    step();
    ipb = 1'b1;
    step();
    ipb = 1'b0;
    wait_done(100);
    @(negedge clk);
    check("gap_idle", {ram_rd_en, c2h_busy}, 64'h0);
    @(negedge clk);
    check("gap_hdr_read", {ram_rd_en, ram_rd_addr}, {1'b1, 11'd0});
    wait_done(100);
    check("pend_count", pkt_count, 64'd2);
    repeat (12) @(negedge clk);
    check("third_dropped", {c2h_busy, pkt_count}, {1'b0, 16'd2});

    // reset during beat 2 of 6
    step();
    set_hdr(16'd10);
    expect_packet();
    ipb = 1'b1;
    @(posedge clk);
    #1;
    ipb = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_beat2", {tvalid, tdata}, {1'b1, 64'hC0DE_0002_5A0E_0002});
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_stream", {tvalid, tlast, tkeep, ram_rd_en, c2h_busy, c2h_done}, 64'h0);
    check("async_rst_data", tdata, 64'h0);
    check("async_rst_count", {pkt_count, len_err}, 64'h0);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    run_pkt(16'd3, 100);
    check("post_rst_pkt", {pkt_count, beats_seen, last_keep}, {16'd1, 32'd3, 8'h0F});

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
